tetris_board_ctrl: RTL
======================

Name: tetris_board_ctrl

Overview:
- Parametrised playfield store and line-clear engine for the Tetris datapath.
- Holds a HEIGHT x WIDTH matrix of colour cells; colour 0 means empty.
- Accepts single-cell writes from the piece-placement logic and answers combinational collision/colour queries for the renderer and mover.
- On commit, compacts away all full rows and reports the count.
- Generalises the fixed 10x20 board to any size; adds out-of-bounds collision, a ready/done handshake, and an optional garbage-row injector.

Parameters:
- WIDTH, 10, columns (x range 0..WIDTH-1).
- HEIGHT, 20, rows (y range 0..HEIGHT-1; y=HEIGHT-1 is the floor row).
- COLOUR_W, 24, bits per cell colour.
- XW, $clog2(WIDTH), x coordinate width (derived).
- YW, $clog2(HEIGHT), y coordinate width (derived).
- GARBAGE_COLOUR, 24'h808080, fill colour for injected rows (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write cell (wr_x, wr_y) with wr_colour.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row.
- wr_colour  in  COLOUR_W  write data; 0 erases the cell.
- commit  in  1  single-cycle pulse: piece placed, start line scan.
- rd_x  in  XW+1  query column (extra bit allows out-of-range values).
- rd_y  in  YW+1  query row.
- occupied  out  1  combinational: cell non-zero, or query out of bounds.
- rd_colour  out  COLOUR_W  combinational cell colour; 0 when out of bounds.
- ready  out  1  block idle; writes and commit accepted.
- done  out  1  one-cycle pulse when a scan (or garbage insert) completes.
- lines_cleared  out  YW+1  rows removed by the last scan; held until the next scan starts.
- garbage_req  in  1  optional feature only: level request to inject a row.
- garbage_hole  in  XW  optional feature only: empty column of the injected row.
- topout  out  1  optional feature only: sticky; a non-empty row 0 was pushed off.

Behaviour:
- Reset: while rst=1, state=CLR, row pointer=HEIGHT-1, ready=0, done=0, lines_cleared=0, topout=0.
- CLR: after rst deasserts, zeroes one row per cycle from HEIGHT-1 down to 0, i.e. HEIGHT cycles; then moves to IDLE with ready=1.
- Reset mid-scan or mid-garbage: abandons the operation and re-enters CLR; the board is fully zeroed.
- IDLE writes: in-range writes land next edge. Out-of-range writes (wr_x>=WIDTH or wr_y>=HEIGHT) are ignored. Writes are ignored whenever ready=0.
- IDLE commit: commit=1 enters SCAN. If wr_en and commit are asserted together, the write is applied first and is included in the scan.
  - SCAN entry sets src=dst=HEIGHT-1 and clears lines_cleared.
  - Each SCAN cycle, if row src is full (all cells non-zero): src--, lines_cleared++.
  - Otherwise, row dst <= row src; then src--, dst--.
  - When src wraps past 0, go to FILL.
- FILL: zero one row per cycle from dst down to 0 (lines_cleared cycles). If lines_cleared=0, FILL is skipped. Then DONE.
- DONE: done=1 for exactly one cycle, ready=0. Next cycle IDLE, ready=1.
- Latency: commit edge to done pulse = HEIGHT + lines_cleared + 1 cycles.
- lines_cleared range: 0..HEIGHT; no saturation needed given the YW+1 width.
- Queries: occupied and rd_colour are combinational at all times. During SCAN/FILL they reflect partially compacted contents; consumers must not rely on them until ready=1.
- commit while ready=0 is ignored (not queued).

Optional Feature:
- Macro: TETRIS_GARBAGE_EN.
- With the macro: garbage_req is sampled only in IDLE with commit=0 (commit has priority, so the request waits).
  - State GARB: topout is set if row 0 is non-empty.
  - Then, over HEIGHT-1 cycles, row y <= row y+1 for y=0..HEIGHT-2.
  - On the final cycle, row HEIGHT-1 <= GARBAGE_COLOUR in every column except garbage_hole (latched at entry), which is 0.
  - Then DONE with the usual done pulse; lines_cleared is unchanged.
  - topout clears only on rst.
- Without the macro: garbage_req, garbage_hole and topout ports are absent, and the GARB state is not compiled.

Decomposition:
- Package board_pkg holds:
  - the state enum {CLR, IDLE, SCAN, FILL, GARB, DONE};
  - localparam EMPTY_COLOUR = '0;
  - a row typedef parameterised via the module, i.e. logic [WIDTH-1:0][COLOUR_W-1:0].
- One sub-module, board_row_check: purely combinational. Takes one row and returns full (all cells non-zero) and empty (all cells zero). It is instantiated for row src and for row 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles, release, wait 20 cycles → ready=1 and all 200 cells=0. Pulse rst mid-SCAN → ready=0 for 20 cycles, then the board is all 0.
- Write: write (0,19), (1,19), (2,19), (1,18) with colour 1 → occupied=1, rd_colour=1 at those cells. (0,0) → occupied=0. Query (10,5) and (3,20) → occupied=1, rd_colour=0.
- No clear: commit with the above → done after 21 cycles, lines_cleared=0, board unchanged.
- Single clear: fill row 19 x=3..9, then commit → done after 22 cycles, lines_cleared=1. Cell (1,19)=1, (1,18)=0, (0,19)=0, (9,19)=0.
- Multi clear: fill rows 16..19 completely, put a block at (4,15), commit → lines_cleared=4, (4,19)=1, rows 0..18 empty, done after 25 cycles. Also check a write plus commit in the same cycle, and that writes during ready=0 are ignored.
- TETRIS_GARBAGE_EN: block at (2,0), garbage_req with hole=5 → topout=1. Row 19 = 808080 everywhere except x=5=0. Previous row 19 contents now appear in row 18.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types for the Tetris playfield store.
// Optional garbage-row injector is enabled with `define TETRIS_GARBAGE_EN.
package board_pkg;

    // Controller states; GARB is only reachable when the injector is compiled in.
    typedef enum logic [2:0] {
        CLR,
        IDLE,
        SCAN,
        FILL,
        GARB,
        DONE
    } state_e;

    // Colour value of an empty cell (cast to the cell width at the point of use).
    localparam logic [63:0] EMPTY_COLOUR = '0;

endpackage

// File: rtl/board_row_check.sv
// Combinational row classifier: full = every cell non-zero, empty = every cell zero.
module board_row_check
    import board_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int COLOUR_W = 24
) (
    input  logic [WIDTH-1:0][COLOUR_W-1:0] row,
    output logic                           full,
    output logic                           empty
);

    // Reduce the per-cell occupancy flags across the row.
    // NOTE: both outputs get a default before the loop so no latch is inferred.
    always_comb begin
        full  = 1'b1;
        empty = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            if (row[c] == COLOUR_W'(EMPTY_COLOUR)) full  = 1'b0;
            else                                   empty = 1'b0;
        end
    end

endmodule

// File: rtl/tetris_board_ctrl.sv
// Playfield store and line-clear engine: HEIGHT x WIDTH colour cells,
// single-cell writes, combinational queries, and full-row compaction on commit.
// Define TETRIS_GARBAGE_EN to add the garbage-row injector (garbage_req,
// garbage_hole, topout ports and the GARB state).
module tetris_board_ctrl
    import board_pkg::*;
#(
    parameter int                    WIDTH          = 10,
    parameter int                    HEIGHT         = 20,
    parameter int                    COLOUR_W       = 24,
    parameter int                    XW             = $clog2(WIDTH),
    parameter int                    YW             = $clog2(HEIGHT),
    parameter logic [COLOUR_W-1:0]   GARBAGE_COLOUR = 24'h808080
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [XW-1:0]       wr_x,
    input  logic [YW-1:0]       wr_y,
    input  logic [COLOUR_W-1:0] wr_colour,
    input  logic                commit,
    input  logic [XW:0]         rd_x,
    input  logic [YW:0]         rd_y,
    output logic                occupied,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                ready,
    output logic                done,
    output logic [YW:0]         lines_cleared
`ifdef TETRIS_GARBAGE_EN
    ,
    input  logic                garbage_req,
    input  logic [XW-1:0]       garbage_hole,
    output logic                topout
`endif
);

    typedef logic [WIDTH-1:0][COLOUR_W-1:0] row_t;

    row_t          board [HEIGHT];
    state_e        state;
    logic [YW-1:0] row_ptr;   // CLR sweep, SCAN/FILL destination, GARB shift row
    logic [YW:0]   src;       // SCAN source row; MSB set means it wrapped past 0
    logic          src_full, src_empty, row0_full, row0_empty;
    logic          wr_ok, rd_in;
    logic          unused_flags;
`ifdef TETRIS_GARBAGE_EN
    logic [XW-1:0] hole;
`endif

    board_row_check #(.WIDTH(WIDTH), .COLOUR_W(COLOUR_W)) u_src_check (
        .row   (board[src[YW-1:0]]),
        .full  (src_full),
        .empty (src_empty)
    );

    board_row_check #(.WIDTH(WIDTH), .COLOUR_W(COLOUR_W)) u_row0_check (
        .row   (board[0]),
        .full  (row0_full),
        .empty (row0_empty)
    );

`ifdef TETRIS_GARBAGE_EN
    assign unused_flags = src_empty | row0_full;
`else
    assign unused_flags = src_empty | row0_full | row0_empty;
`endif

    assign wr_ok = wr_en && ({1'b0, wr_x} < (XW+1)'(WIDTH)) && ({1'b0, wr_y} < (YW+1)'(HEIGHT));
    assign rd_in = (rd_x < (XW+1)'(WIDTH)) && (rd_y < (YW+1)'(HEIGHT));

    // Query port: out-of-bounds reads as an occupied wall with no colour.
    always_comb begin
        rd_colour = COLOUR_W'(EMPTY_COLOUR);
        if (rd_in) rd_colour = board[rd_y[YW-1:0]][rd_x[XW-1:0]];
        occupied = !rd_in || (rd_colour != COLOUR_W'(EMPTY_COLOUR));
    end

    // Controller FSM with registered outputs; owns every board write.
    // NOTE: the board array is never touched by rst -- the CLR sweep zeroes it
    // row by row, so the storage stays a plain write-port memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CLR;
            row_ptr       <= YW'(HEIGHT-1);
            src           <= (YW+1)'(HEIGHT-1);
            ready         <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
`ifdef TETRIS_GARBAGE_EN
            topout        <= 1'b0;
            hole          <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                CLR: begin
                    board[row_ptr] <= '0;
                    if (row_ptr == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        row_ptr <= row_ptr - 1'b1;
                    end
                end
                IDLE: begin
                    if (wr_ok) board[wr_y][wr_x] <= wr_colour;
                    if (commit) begin
                        state         <= SCAN;
                        src           <= (YW+1)'(HEIGHT-1);
                        row_ptr       <= YW'(HEIGHT-1);
                        lines_cleared <= '0;
                        ready         <= 1'b0;
                    end
`ifdef TETRIS_GARBAGE_EN
                    else if (garbage_req) begin
                        state   <= GARB;
                        hole    <= garbage_hole;
                        row_ptr <= '0;
                        ready   <= 1'b0;
                    end
`endif
                end
                SCAN: begin
                    if (src[YW]) begin
                        if (lines_cleared == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end else if (src_full) begin
                        lines_cleared <= lines_cleared + 1'b1;
                        src           <= src - 1'b1;
                    end else begin
                        board[row_ptr] <= board[src[YW-1:0]];
                        src            <= src - 1'b1;
                        row_ptr        <= row_ptr - 1'b1;
                    end
                end
                FILL: begin
                    board[row_ptr] <= '0;
                    if (row_ptr == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        row_ptr <= row_ptr - 1'b1;
                    end
                end
`ifdef TETRIS_GARBAGE_EN
                GARB: begin
                    if (row_ptr == '0 && !row0_empty) topout <= 1'b1;
                    board[row_ptr] <= board[row_ptr + 1'b1];
                    if (row_ptr == YW'(HEIGHT-2)) begin
                        for (int c = 0; c < WIDTH; c++) begin
                            board[HEIGHT-1][c] <= (XW'(c) == hole) ? COLOUR_W'(EMPTY_COLOUR)
                                                                   : GARBAGE_COLOUR;
                        end
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        row_ptr <= row_ptr + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= CLR;
                    row_ptr <= YW'(HEIGHT-1);
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
